// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard-detection and forwarding controller for the in-order pipeline.
//   A shift-register scoreboard holds one {valid, dst, is_load} entry per
//   post-decode stage (sb[0] = EX ... sb[DEPTH-1] = WB). From it the block
//   derives the EX forwarding selects, the load-use stall for the
//   instruction in ID, and the IF/ID flush / ID/EX bubble controls.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid                  real instruction in ID
//   id_rs, id_rt              ID source registers
//   id_uses_rs, id_uses_rt    source operand actually read
//   id_reg_write              ID instruction writes a register
//   id_mem_read               ID instruction is a load
//   id_wr_reg                 ID destination register
//   branch_taken              branch resolved taken in ID
//   ex_redirect               redirect from EX, kills ID and IF
//   pc_write, ifid_write      PC / IF/ID enables
//   ifid_flush                zero the IF/ID register
//   idex_bubble               insert zero controls into ID/EX
//   fwd_a, fwd_b              EX operand select (0 = ID/EX value, j = stage j bus)
//   stall_cycles, flush_events  saturating event counters (HAZARD_PERF_CNT_EN only)
//
// Build option
//   HAZARD_PERF_CNT_EN  adds the stall_cycles / flush_events counters.
module hazard_scoreboard #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned FWD_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              branch_taken,
  input  logic              ex_redirect,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events,
`endif
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b
);

  // Scoreboard, index 0 is the EX stage.
  logic [DEPTH-1:0]             r_sb_valid;
  logic [DEPTH-1:0]             r_sb_load;
  logic [DEPTH-1:0][REG_AW-1:0] r_sb_dst;

  // Source operands of the instruction currently in EX.
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_ex_uses_rs;
  logic              r_ex_uses_rt;

  logic w_stall_a;
  logic w_stall_b;
  logic w_stall;
  logic w_adv;
  logic w_new_valid;

  // Load-use detection. Scanning from old to young and overwriting makes the
  // youngest match decide, so an older ALU producer behind a younger load
  // cannot mask the stall. sb[DEPTH-1] is excluded: the register file
  // returns same-cycle write data.
  always_comb begin
    w_stall_a = 1'b0;
    w_stall_b = 1'b0;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      if (r_sb_valid[k] && (r_sb_dst[k] == id_rs)) begin
        w_stall_a = r_sb_load[k] && ((k + 1) < int'(LOAD_STAGE));
      end
      if (r_sb_valid[k] && (r_sb_dst[k] == id_rt)) begin
        w_stall_b = r_sb_load[k] && ((k + 1) < int'(LOAD_STAGE));
      end
    end
    w_stall = !rst && ((id_uses_rs && w_stall_a) || (id_uses_rt && w_stall_b));
  end

  assign w_adv       = id_valid && !w_stall && !ex_redirect;
  assign w_new_valid = w_adv && id_reg_write && (id_wr_reg != '0);

  // Forwarding select: smallest stage index (youngest producer) wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int j = int'(DEPTH) - 1; j >= 1; j--) begin
      if (r_ex_uses_rs && r_sb_valid[j] && (r_sb_dst[j] == r_ex_rs)) begin
        fwd_a = FWD_W'(j);
      end
      if (r_ex_uses_rt && r_sb_valid[j] && (r_sb_dst[j] == r_ex_rt)) begin
        fwd_b = FWD_W'(j);
      end
    end
  end

  // Pipeline control, priority redirect > stall > branch. Gated by rst so
  // the outputs fall back to their idle values as soon as reset asserts.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      // idle values
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_valid   <= '0;
      r_sb_load    <= '0;
      r_sb_dst     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_uses_rs <= 1'b0;
      r_ex_uses_rt <= 1'b0;
    end else begin
      r_sb_valid   <= {r_sb_valid[DEPTH-2:0], w_new_valid};
      r_sb_load    <= {r_sb_load[DEPTH-2:0], id_mem_read};
      r_sb_dst     <= {r_sb_dst[DEPTH-2:0], id_wr_reg};
      r_ex_rs      <= w_adv ? id_rs : '0;
      r_ex_rt      <= w_adv ? id_rt : '0;
      r_ex_uses_rs <= w_adv && id_uses_rs;
      r_ex_uses_rt <= w_adv && id_uses_rt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (ifid_flush && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int D  = 3;
  localparam int LS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       branch_taken, ex_redirect;

  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       d5_pc_write, d5_ifid_write, d5_ifid_flush, d5_idex_bubble;
  logic [2:0] d5_fwd_a, d5_fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, d5_stall_cycles, d5_flush_events;
`endif

  logic cmp_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(2), .FWD_W(2)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_wr_reg(id_wr_reg), .branch_taken(branch_taken),
    .ex_redirect(ex_redirect), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  hazard_scoreboard #(.REG_AW(5), .DEPTH(5), .LOAD_STAGE(3), .FWD_W(3)) u_dut5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_wr_reg(id_wr_reg), .branch_taken(branch_taken),
    .ex_redirect(ex_redirect), .pc_write(d5_pc_write), .ifid_write(d5_ifid_write),
    .ifid_flush(d5_ifid_flush), .idex_bubble(d5_idex_bubble),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(d5_stall_cycles), .flush_events(d5_flush_events),
`endif
    .fwd_a(d5_fwd_a), .fwd_b(d5_fwd_b)
  );

  // ---------------- reference model (DEPTH=3, LOAD_STAGE=2) ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       ld;
  } ent_t;

  ent_t       m_pipe[$];   // m_pipe[i] = instruction that entered EX i cycles ago
  logic [4:0] m_ex_rs, m_ex_rt;
  logic       m_ex_urs, m_ex_urt;

  // A load is usable once it has reached stage LS; a consumer in ID stalls if
  // the nearest in-flight writer of its source is a load still short of that.
  function automatic logic src_stall(input logic [4:0] src, input logic use_it);
    if (!use_it) return 1'b0;
    for (int k = 0; k <= D - 2; k++) begin
      if (m_pipe[k].v && m_pipe[k].dst == src) return m_pipe[k].ld && (k + 1 < LS);
    end
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    return src_stall(id_rs, id_uses_rs) || src_stall(id_rt, id_uses_rt);
  endfunction

  function automatic int m_fwd(input logic [4:0] src, input logic use_it);
    if (!use_it) return 0;
    for (int j = 1; j <= D - 1; j++) begin
      if (m_pipe[j].v && m_pipe[j].dst == src) return j;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    ent_t e;
    logic adv;
    if (rst) begin
      m_pipe = {};
      for (int i = 0; i < D; i++) m_pipe.push_back('0);
      m_ex_rs = '0; m_ex_rt = '0; m_ex_urs = 1'b0; m_ex_urt = 1'b0;
    end else begin
      adv   = id_valid && !m_stall() && !ex_redirect;
      e.v   = adv && id_reg_write && (id_wr_reg != 5'd0);
      e.dst = id_wr_reg;
      e.ld  = id_mem_read;
      m_pipe.push_front(e);
      void'(m_pipe.pop_back());
      m_ex_rs  = adv ? id_rs : 5'd0;
      m_ex_rt  = adv ? id_rt : 5'd0;
      m_ex_urs = adv && id_uses_rs;
      m_ex_urt = adv && id_uses_rt;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic st;
    int e_pc, e_wr, e_fl, e_bb;
    if (cmp_en && !rst) begin
      st = m_stall();
      e_pc = 1; e_wr = 1; e_fl = 0; e_bb = 0;
      if (ex_redirect) begin
        e_fl = 1; e_bb = 1;
      end else if (st) begin
        e_pc = 0; e_wr = 0; e_bb = 1;
      end else if (branch_taken) begin
        e_fl = 1;
      end
      chk("model_pc_write", int'(pc_write), e_pc);
      chk("model_ifid_write", int'(ifid_write), e_wr);
      chk("model_ifid_flush", int'(ifid_flush), e_fl);
      chk("model_idex_bubble", int'(idex_bubble), e_bb);
      chk("model_fwd_a", int'(fwd_a), m_fwd(m_ex_rs, m_ex_urs));
      chk("model_fwd_b", int'(fwd_b), m_fwd(m_ex_rt, m_ex_urt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic mr, input logic [4:0] wr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_wr_reg = wr;
  endtask

  task automatic id_nop();
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    branch_taken = 1'b0;
    ex_redirect  = 1'b0;
  endtask

  task automatic drain();
    id_nop();
    repeat (6) next();
  endtask

  initial begin
    rst = 1'b1;
    id_nop();
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    at_neg();
    chk("reset_pc_write", int'(pc_write), 1);
    chk("reset_ifid_write", int'(ifid_write), 1);
    chk("reset_flush_bubble", int'({ifid_flush, idex_bubble}), 0);
    chk("reset_fwd", int'({fwd_a, fwd_b}), 0);
    next();
    rst = 1'b0;
    next();

    // lw $5 ; add $6,$5,$7 -> one stall cycle, then fwd_a=2
    id_set(1, 0, 0, 0, 0, 1, 1, 5'd5);
    next();
    id_set(1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6);
    at_neg();
    chk("lu_stall_pc_write", int'(pc_write), 0);
    chk("lu_stall_bubble", int'(idex_bubble), 1);
    next();
    at_neg();
    chk("lu_release_pc_write", int'(pc_write), 1);
    next();
    id_nop();
    at_neg();
    chk("lu_fwd_a_wb", int'(fwd_a), 2);
    chk("lu_fwd_b_none", int'(fwd_b), 0);
    drain();

    // add $3,$1,$2 ; sub $4,$3,$3 -> no stall, fwd 1/1
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
    next();
    id_set(1, 5'd3, 5'd3, 1, 1, 1, 0, 5'd4);
    at_neg();
    chk("alu_no_stall", int'(pc_write), 1);
    next();
    id_nop();
    at_neg();
    chk("alu_fwd_a", int'(fwd_a), 1);
    chk("alu_fwd_b", int'(fwd_b), 1);
    drain();

    // add $3 ; add $3 ; or $8,$3,$0 -> youngest wins
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
    next();
    id_set(1, 5'd4, 5'd5, 1, 1, 1, 0, 5'd3);
    next();
    id_set(1, 5'd3, 5'd0, 1, 1, 1, 0, 5'd8);
    next();
    id_nop();
    at_neg();
    chk("youngest_fwd_a", int'(fwd_a), 1);
    chk("zero_reg_fwd_b", int'(fwd_b), 0);
    drain();

    // load to $0 then reader of $0 -> no stall, no forwarding
    id_set(1, 0, 0, 0, 0, 1, 1, 5'd0);
    next();
    id_set(1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd9);
    at_neg();
    chk("r0_no_stall", int'({pc_write, idex_bubble}), 2);
    next();
    id_nop();
    at_neg();
    chk("r0_no_fwd", int'({fwd_a, fwd_b}), 0);
    drain();

    // stall beats a simultaneous branch; branch acts next cycle
    id_set(1, 0, 0, 0, 0, 1, 1, 5'd5);
    next();
    id_set(1, 5'd7, 5'd5, 1, 1, 0, 0, 5'd0);
    branch_taken = 1'b1;
    at_neg();
    chk("br_stall_flush", int'(ifid_flush), 0);
    chk("br_stall_pc_write", int'(pc_write), 0);
    next();
    at_neg();
    chk("br_after_flush", int'(ifid_flush), 1);
    chk("br_after_bubble", int'(idex_bubble), 0);
    next();
    drain();

    // redirect during a stall
    id_set(1, 0, 0, 0, 0, 1, 1, 5'd5);
    next();
    id_set(1, 5'd5, 5'd2, 1, 1, 1, 0, 5'd6);
    ex_redirect = 1'b1;
    at_neg();
    chk("redir_ctrl", int'({ifid_flush, idex_bubble, pc_write, ifid_write}), 15);
    next();
    drain();

    // reset asserted mid-stall drops everything immediately
    id_set(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd5);
    next();
    id_set(1, 0, 0, 0, 0, 1, 1, 5'd5);
    next();
    id_set(1, 5'd5, 5'd6, 1, 1, 1, 0, 5'd7);
    at_neg();
    chk("pre_rst_stall", int'(pc_write), 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", int'({pc_write, ifid_write, ifid_flush, idex_bubble}), 12);
    chk("async_rst_fwd", int'({fwd_a, fwd_b}), 0);
    next();
    rst = 1'b0;
    drain();

    // DEPTH=5, LOAD_STAGE=3: two stall cycles then fwd from stage 3
    id_set(1, 0, 0, 0, 0, 1, 1, 5'd5);
    next();
    id_set(1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6);
    at_neg();
    chk("d5_stall_1", int'(d5_pc_write), 0);
    next();
    at_neg();
    chk("d5_stall_2", int'(d5_pc_write), 0);
    next();
    at_neg();
    chk("d5_release", int'(d5_pc_write), 1);
    next();
    id_nop();
    at_neg();
    chk("d5_fwd_a", int'(d5_fwd_a), 3);
    drain();

    // randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_wr_reg    = 5'($urandom_range(0, 7));
      branch_taken = ($urandom_range(0, 7) == 0);
      ex_redirect  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      next();
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard-detection and forwarding controller for the in-order pipeline datapath. It replaces the fixed 3-bit forwardA/forwardB and stall_needed/ifidFlush control.
- Tracks in-flight destination registers in a shift-register scoreboard, one entry per post-decode stage.
- Generates forwarding selects for the instruction in EX.
- Generates load-use stalls and IF/ID and ID/EX flushes.
- Pipeline depth, register-address width and load-data stage are all configurable.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero and never matches.
- DEPTH, 3, post-decode stages tracked (sb[0]=EX … sb[DEPTH-1]=last/WB); legal range 2..8.
- LOAD_STAGE, 2, first stage index at which load data can be forwarded; legal range 1..DEPTH-1.
- FWD_W, $clog2(DEPTH), width of the forwarding select.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  real instruction in ID
- id_rs, id_rt  in  REG_AW  ID source registers
- id_uses_rs, id_uses_rt  in  1  source operand actually read
- id_reg_write  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- id_wr_reg  in  REG_AW  ID destination register (after regDst mux)
- branch_taken  in  1  branch resolved taken in ID
- ex_redirect  in  1  redirect from EX (exception/mispredict); kills ID and IF
- pc_write  out  1  PC enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  zero the IF/ID register
- idex_bubble  out  1  insert zero controls into ID/EX
- fwd_a, fwd_b  out  FWD_W  EX operand select: 0 = ID/EX value; j = result bus of stage j (1..DEPTH-1)

Behaviour:
- Scoreboard entry sb[i] = {valid, dst, is_load}. An entry is valid only if id_reg_write=1 and dst≠0.
- Each clock edge:
  - sb[i] <= sb[i-1] for i≥1.
  - sb[0] <= ID instruction if advancing (id_valid, no stall, no redirect); otherwise sb[0] <= invalid.
  - ex_rs/ex_rt/ex_uses latch from ID under the same condition; otherwise they latch zero/unused.
- fwd_a (combinational, for the instruction in EX):
  - Find the smallest j in 1..DEPTH-1 with sb[j].valid, sb[j].dst==ex_rs, ex_uses_rs=1.
  - fwd_a = j if found, else 0. fwd_b is identical using ex_rt.
  - Youngest producer always wins.
- Load-use stall (combinational, for the instruction in ID):
  - Find the youngest matching sb[k], k in 0..DEPTH-2, per used source.
  - stall = 1 if that entry is_load and k+1 < LOAD_STAGE. Older non-load matches behind a younger load do not cancel the stall.
  - A match at sb[DEPTH-1] never stalls; the register file returns same-cycle write data.
- Priority: ex_redirect > stall > branch_taken.
  - ex_redirect: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - stall: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. A simultaneous branch_taken is ignored and re-evaluated on the next cycle.
  - branch_taken (no stall): ifid_flush=1, pc_write=1, ifid_write=1, idex_bubble=0.
  - default: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Reset:
  - All sb entries invalid; ex latches zero.
  - Outputs: fwd_a=fwd_b=0, pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
  - Reset asserted mid-stall drops the stall immediately.
- Latency: stall resolves after LOAD_STAGE-1-k cycles (1 cycle at defaults with k=0); there is no other added latency.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output ports stall_cycles (32) and flush_events (32), both cleared by rst.
  - stall_cycles increments every cycle stall=1.
  - flush_events increments every cycle ifid_flush=1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- lw $5 then add $6,$5,$7 back-to-back (defaults) -> 1 cycle pc_write=0/idex_bubble=1; then add in EX with fwd_a=2 (WB).
- add $3,$1,$2 then sub $4,$3,$3 -> no stall; sub in EX sees fwd_a=fwd_b=1.
- add $3 ; add $3 ; or $8,$3,$0 -> or in EX gets fwd_a=1 (youngest), fwd_b=0.
- Write to $0 followed by a reader of $0 -> fwd 0, no stall.
- branch_taken with load-use stall in same cycle -> stall wins, ifid_flush=0; next cycle branch_taken -> ifid_flush=1.
- ex_redirect during stall -> ifid_flush=1, idex_bubble=1, pc_write=1. Assert rst mid-sequence -> all outputs return to reset values asynchronously.
- DEPTH=5, LOAD_STAGE=3: load then dependent instruction -> 2 stall cycles, then fwd=3.
